// File: rtl/riscv_dmem_responder_pkg.sv
// Shared definitions for the RISC-V data-memory responder.
// Holds the FSM state encoding, the byte-to-word address offset and the
// address-fault helper used in the idle-state request check.
package riscv_dmem_responder_pkg;

  // FSM state encoding (3 bits)
  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWrite    = 3'd1;
  localparam logic [2:0] StReadWait = 3'd2;
  localparam logic [2:0] StDone     = 3'd3;
  localparam logic [2:0] StFault    = 3'd4;

  // Byte address bits below the word address
  localparam int unsigned WordOffset = 2;

  // An access is rejected when it is not word aligned or when any bit above
  // the RAM's word-address range is set.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned addr_width);
    logic [31:0] upper;
    upper = addr >> (addr_width + WordOffset);
    return (addr[WordOffset-1:0] != '0) || (upper != '0);
  endfunction

endpackage

// File: rtl/riscv_dmem_responder_if.sv
// CPU-side data-memory port of the RISC-V core.
// master: the CPU (drives address/enables/write data, receives read data,
//         pipeline stall and fault pulse).
// slave:  the memory responder.
interface riscv_dmem_responder_if;

  logic [31:0] memoryAddress;
  logic        memoryReadEnable;
  logic        memoryWriteEnable;
  logic [31:0] memoryWriteData;
  logic [31:0] memoryReadData;
  logic        stall;
  logic        addressFault;

  modport master (
    output memoryAddress,
    output memoryReadEnable,
    output memoryWriteEnable,
    output memoryWriteData,
    input  memoryReadData,
    input  stall,
    input  addressFault
  );

  modport slave (
    input  memoryAddress,
    input  memoryReadEnable,
    input  memoryWriteEnable,
    input  memoryWriteData,
    output memoryReadData,
    output stall,
    output addressFault
  );

endinterface

// File: rtl/riscv_dmem_latency_counter.sv
// Down-counter that times the backing-RAM read latency.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset (counter clears to 0)
//   load_i  load LATENCY-1
//   dec_i   decrement (saturates at 0)
//   zero_o  counter equals 0
module riscv_dmem_latency_counter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned CntW = $clog2(LATENCY) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(LATENCY - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: services the CPU's word-wide data port from a
// multi-cycle backing RAM and holds the pipeline (stall) while a load or the
// request cycle of any access is outstanding.
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   cpu       CPU data-memory port (slave modport)
//   ramAddr   backing-RAM word address
//   ramWe     backing-RAM write strobe, one cycle per store
//   ramWdata  backing-RAM write data
//   ramRdata  backing-RAM read data, LATENCY edges after ramAddr
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_dmem_responder_if.slave cpu,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  output logic                  ramWe,
  output logic [31:0]           ramWdata,
  input  logic [31:0]           ramRdata
);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [31:0]           read_q, read_d;

  logic        cnt_load, cnt_dec, cnt_zero;
  logic        req;
  logic        stall_raw;
  logic        fault_pulse;
  logic [31:0] rdata;
  logic [ADDR_WIDTH-1:0] cpu_word_addr;

  assign req           = cpu.memoryReadEnable | cpu.memoryWriteEnable;
  assign cpu_word_addr = cpu.memoryAddress[ADDR_WIDTH+WordOffset-1:WordOffset];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    read_d      = read_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    stall_raw   = 1'b0;
    ramWe       = 1'b0;
    fault_pulse = 1'b0;
    rdata       = read_q;
    ramAddr     = addr_q;

    unique case (state_q)
      StIdle: begin
        // Present the address straight away so the RAM read starts this cycle
        ramAddr = cpu_word_addr;
        if (req) begin
          stall_raw = 1'b1;
          addr_d    = cpu_word_addr;
          wdata_d   = cpu.memoryWriteData;
          // Write wins when both enables are high
          write_d   = cpu.memoryWriteEnable;
          if (addr_fault(cpu.memoryAddress, ADDR_WIDTH)) begin
            state_d = StFault;
          end else if (cpu.memoryWriteEnable) begin
            state_d = StWrite;
          end else begin
            state_d  = StReadWait;
            cnt_load = 1'b1;
          end
        end
      end
      StWrite: begin
        ramWe   = 1'b1;
        state_d = StIdle;
      end
      StReadWait: begin
        stall_raw = 1'b1;
        if (cnt_zero) begin
          state_d = StDone;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StDone: begin
        rdata   = ramRdata;
        read_d  = ramRdata;
        state_d = StIdle;
      end
      StFault: begin
        fault_pulse = 1'b1;
        // A rejected store leaves the last load value visible
        if (!write_q) begin
          rdata  = '0;
          read_d = '0;
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      read_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      read_q  <= read_d;
    end
  end

  riscv_dmem_latency_counter #(
    .LATENCY (LATENCY)
  ) u_latency_counter (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  // The idle-request stall is combinational on the inputs, so gate it with
  // reset directly to release the CPU the moment reset is applied.
  assign cpu.stall          = stall_raw & rst;
  assign cpu.addressFault   = fault_pulse;
  assign cpu.memoryReadData = rdata;
  assign ramWdata           = wdata_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
module tb_riscv_dmem_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] ramAddr;
  logic          ramWe;
  logic [31:0]   ramWdata;
  logic [31:0]   ramRdata;

  riscv_dmem_responder_if bus ();

  riscv_dmem_responder #(
    .ADDR_WIDTH (AW),
    .LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu      (bus.slave),
    .ramAddr  (ramAddr),
    .ramWe    (ramWe),
    .ramWdata (ramWdata),
    .ramRdata (ramRdata)
  );

  always #5 clk = ~clk;

  // Backing RAM: synchronous write, read data reflects ramAddr sampled LAT edges earlier
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] ra1 = '0;
  logic [AW-1:0] ra2 = '0;
  always @(posedge clk) begin
    if (ramWe) mem[ramAddr] <= ramWdata;
    ra1 <= ramAddr;
    ra2 <= ra1;
  end
  assign ramRdata = mem[ra2];

  // Reference state kept by the bench
  logic [31:0] mdl [0:(1<<AW)-1];
  logic [31:0] last_rd;
  logic [31:0] exp_q[$];

  int total = 0;
  int bad   = 0;

  function automatic logic is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.memoryAddress     = '0;
    bus.memoryReadEnable  = 1'b0;
    bus.memoryWriteEnable = 1'b0;
    bus.memoryWriteData   = '0;
    repeat (3) cyc();
    rst = 1'b1;
    last_rd = '0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      total++;
      if (bus.stall !== 1'b0 || ramWe !== 1'b0 || bus.memoryReadData !== 32'd0
          || bus.addressFault !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: stall=%b we=%b rd=%h flt=%b, want 0/0/0/0",
                 i, bus.stall, ramWe, bus.memoryReadData, bus.addressFault);
      end
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic both);
    logic flt;
    flt = is_fault(a);
    cyc();
    bus.memoryAddress     = a;
    bus.memoryWriteData   = d;
    bus.memoryWriteEnable = 1'b1;
    bus.memoryReadEnable  = both;
    #1;
    total++;
    if (bus.stall !== 1'b1 || ramWe !== 1'b0) begin
      bad++;
      $display("FAIL store_req %h: stall=%b we=%b, want 1/0", a, bus.stall, ramWe);
    end
    cyc();
    bus.memoryWriteEnable = 1'b0;
    bus.memoryReadEnable  = 1'b0;
    #1;
    total++;
    if (flt) begin
      if (bus.stall !== 1'b0 || ramWe !== 1'b0 || bus.addressFault !== 1'b1
          || bus.memoryReadData !== last_rd) begin
        bad++;
        $display("FAIL store_fault %h: stall=%b we=%b flt=%b rd=%h, want 0/0/1/%h",
                 a, bus.stall, ramWe, bus.addressFault, bus.memoryReadData, last_rd);
      end
    end else begin
      if (bus.stall !== 1'b0 || ramWe !== 1'b1 || ramAddr !== a[AW+1:2] || ramWdata !== d
          || bus.addressFault !== 1'b0 || bus.memoryReadData !== last_rd) begin
        bad++;
        $display("FAIL store_commit %h: stall=%b we=%b addr=%h wd=%h flt=%b rd=%h, want 0/1/%h/%h/0/%h",
                 a, bus.stall, ramWe, ramAddr, ramWdata, bus.addressFault,
                 bus.memoryReadData, a[AW+1:2], d, last_rd);
      end
      mdl[a[AW+1:2]] = d;
    end
    cyc();
    #1;
    total++;
    if (ramWe !== 1'b0 || bus.addressFault !== 1'b0 || bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL store_after %h: we=%b flt=%b stall=%b, want 0/0/0",
               a, ramWe, bus.addressFault, bus.stall);
    end
  endtask

  task automatic do_load(input logic [31:0] a);
    logic        flt;
    logic [31:0] exp;
    int          n;
    flt = is_fault(a);
    exp_q.push_back(flt ? 32'd0 : mdl[a[AW+1:2]]);
    cyc();
    bus.memoryAddress    = a;
    bus.memoryReadEnable = 1'b1;
    #1;
    total++;
    if (bus.stall !== 1'b1) begin
      bad++;
      $display("FAIL load_req %h: stall=%b, want 1", a, bus.stall);
    end
    n = 0;
    do begin
      cyc();
      bus.memoryReadEnable = 1'b0;
      #1;
      n++;
      total++;
      if (!flt && n <= LAT && ramAddr !== a[AW+1:2]) begin
        bad++;
        $display("FAIL load_hold %h cyc%0d: addr=%h, want %h", a, n, ramAddr, a[AW+1:2]);
      end
    end while (bus.stall === 1'b1 && n < 20);
    exp = exp_q.pop_front();
    total++;
    if (n !== (flt ? 1 : LAT + 1)) begin
      bad++;
      $display("FAIL load_latency %h: cycles=%0d, want %0d", a, n, flt ? 1 : LAT + 1);
    end
    total++;
    if (bus.memoryReadData !== exp || bus.addressFault !== flt || ramWe !== 1'b0) begin
      bad++;
      $display("FAIL load_data %h: rd=%h flt=%b we=%b, want %h/%b/0",
               a, bus.memoryReadData, bus.addressFault, ramWe, exp, flt);
    end
    last_rd = exp;
    cyc();
    #1;
    total++;
    if (bus.memoryReadData !== last_rd || bus.stall !== 1'b0 || bus.addressFault !== 1'b0) begin
      bad++;
      $display("FAIL load_persist %h: rd=%h stall=%b flt=%b, want %h/0/0",
               a, bus.memoryReadData, bus.stall, bus.addressFault, last_rd);
    end
  endtask

  task automatic test_store_load();
    do_store(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    do_load(32'h0000_0010);
  endtask

  task automatic test_fault();
    do_load(32'h0000_0012);
    do_load(32'h0000_0010);
    do_store(32'h0000_1000, 32'hCAFE_F00D, 1'b0);
    do_load(32'h0000_0000);
  endtask

  task automatic test_both_enables();
    do_load(32'h0000_0010);
    do_store(32'h0000_0008, 32'h1234_5678, 1'b1);
    do_load(32'h0000_0008);
  endtask

  task automatic test_reset_mid();
    int n;
    do_load(32'h0000_0010);
    cyc();
    bus.memoryAddress    = 32'h0000_0008;
    bus.memoryReadEnable = 1'b1;
    cyc();
    bus.memoryReadEnable = 1'b0;
    // now in the read-latency wait
    rst = 1'b0;
    #1;
    total++;
    if (bus.stall !== 1'b0 || bus.memoryReadData !== 32'd0 || ramWe !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: stall=%b rd=%h we=%b, want 0/0/0",
               bus.stall, bus.memoryReadData, ramWe);
    end
    cyc();
    rst = 1'b1;
    last_rd = '0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      if (bus.stall !== 1'b0 || bus.memoryReadData !== 32'd0) n++;
    end
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL reset_mid_idle: bad idle cycles=%0d, want 0", n);
    end
    do_load(32'h0000_0008);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_store(32'h0000_0100 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 1'b0);
    end
    for (int i = 3; i >= 0; i--) begin
      do_load(32'h0000_0100 + 32'(i * 4));
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 32'h0;
      mdl[i] = 32'h0;
    end
    test_reset();
    test_store_load();
    test_fault();
    test_both_enables();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
